inv_key_schedule: RTL

Round-key source for the decryption datapath. Accepts the 128-bit cipher key, runs the forward AES-128 key expansion to round 10, then delivers round keys in reverse order (10 down to 0), one step per consumer request. It uses the inverse key recurrence, so only one round key is stored. It feeds the round-key XOR stage of the inverse cipher, whose round sequencer pulls keys with `next`.

---
 rtl/inv_key_schedule_if.sv | 34 +++
 rtl/inv_key_schedule.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule_if.sv
// Round-key request/response bundle between the inverse-cipher round sequencer
// (master) and inv_key_schedule (slave).
//   load      : one-cycle pulse, capture key and start expansion
//   key       : cipher key, byte i at [i*8 +: 8]
//   next      : request the next lower round key
//   round_key : current round key, same byte order as key
//   round_idx : round number of round_key (10..0)
//   valid     : round_key/round_idx meaningful
//   busy      : forward expansion running
//   done      : round 0 key presented
interface inv_key_schedule_if;
    localparam int unsigned WORD_SIZE  = 8;
    localparam int unsigned ARRAY_SIZE = 16;
    localparam int unsigned KEY_W      = WORD_SIZE * ARRAY_SIZE;

    logic             load;
    logic [KEY_W-1:0] key;
    logic             next;
    logic [KEY_W-1:0] round_key;
    logic [3:0]       round_idx;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output load, key, next,
        input  round_key, round_idx, valid, busy, done
    );

    modport slave (
        input  load, key, next,
        output round_key, round_idx, valid, busy, done
    );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 round-key source for decryption. Expands the cipher key forward to
// round 10, then walks back to round 0 with the inverse key recurrence, one
// round per `next`. Only the current round key is stored; a single 4-byte
// S-box is shared between the forward and inverse steps.
// Ports: clk, rst (async, active-high), kif (inv_key_schedule_if.slave).
// Option: define INV_KEY_MIX_EN to present InvMixColumns(round key) for rounds
// 1..9 (equivalent inverse cipher); this output path is combinational.
module inv_key_schedule (
    input  logic                 clk,
    input  logic                 rst,
    inv_key_schedule_if.slave    kif
);
    localparam int unsigned KEY_W = 128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_SERVE  = 2'd2;

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as a^254 (0 maps to 0), then affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef INV_KEY_MIX_EN
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[7:0];
        b1 = w[15:8];
        b2 = w[23:16];
        b3 = w[31:24];
        return {gf_mul(b0, 8'h0b) ^ gf_mul(b1, 8'h0d) ^ gf_mul(b2, 8'h09) ^ gf_mul(b3, 8'h0e),
                gf_mul(b0, 8'h0d) ^ gf_mul(b1, 8'h09) ^ gf_mul(b2, 8'h0e) ^ gf_mul(b3, 8'h0b),
                gf_mul(b0, 8'h09) ^ gf_mul(b1, 8'h0e) ^ gf_mul(b2, 8'h0b) ^ gf_mul(b3, 8'h0d),
                gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09)};
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w3_inv, sub_in, sub_out;
    logic [3:0]  rc_round;
    logic [31:0] fw0, fw1, fw2, fw3;
    logic [31:0] iw0;

    // Shared SubWord(RotWord()) lookup and both step directions
    always_comb begin
        w0 = key_q[31:0];
        w1 = key_q[63:32];
        w2 = key_q[95:64];
        w3 = key_q[127:96];

        w3_inv   = w3 ^ w2;
        sub_in   = (state_q == ST_EXPAND) ? w3 : w3_inv;
        rc_round = (state_q == ST_EXPAND) ? idx_q + 4'd1 : idx_q;
        for (int b = 0; b < 4; b++) begin
            sub_out[b*8 +: 8] = sbox(sub_in[((b + 1) % 4)*8 +: 8]);
        end

        fw0 = w0 ^ sub_out ^ {24'h000000, rcon(rc_round)};
        fw1 = w1 ^ fw0;
        fw2 = w2 ^ fw1;
        fw3 = w3 ^ fw2;

        // Recovered w3 feeds the S-box term of the recovered w0
        iw0 = w0 ^ sub_out ^ {24'h000000, rcon(rc_round)};
    end

    // Next-state and registered-output logic; load overrides everything
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;

        if (kif.load) begin
            state_d = ST_EXPAND;
            key_d   = kif.key;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    key_d = {fw3, fw2, fw1, fw0};
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd9) state_d = ST_SERVE;
                end
                ST_SERVE: begin
                    if (kif.next && (idx_q != 4'd0)) begin
                        key_d = {w3_inv, w2 ^ w1, w1 ^ w0, iw0};
                        idx_d = idx_q - 4'd1;
                    end
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        valid_d = (state_d == ST_SERVE);
        busy_d  = (state_d == ST_EXPAND);
        done_d  = valid_d && (idx_d == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef INV_KEY_MIX_EN
    // Rounds 1..9 leave through InvMixColumns; rounds 0 and 10 stay raw
    always_comb begin
        if ((idx_q != 4'd0) && (idx_q != 4'd10)) begin
            kif.round_key = {inv_mix_word(w3), inv_mix_word(w2),
                             inv_mix_word(w1), inv_mix_word(w0)};
        end else begin
            kif.round_key = key_q;
        end
    end
`else
    assign kif.round_key = key_q;
`endif

    assign kif.round_idx = idx_q;
    assign kif.valid     = valid_q;
    assign kif.busy      = busy_q;
    assign kif.done      = done_q;
endmodule
